a_input_debouncer: RTL and testbench

// - Conditions a raw, asynchronous, possibly bouncing pushbutton/switch into the clean

---
 rtl/a_input_debouncer_pkg.sv | 20 ++
 rtl/a_input_debouncer_if.sv | 27 ++
 rtl/a_input_debouncer_sync_chain.sv | 27 ++
 rtl/a_input_debouncer.sv | 107 ++++++++++
 tb/tb_a_input_debouncer.sv | 194 +++++++++++++++++++
 5 files changed

// File: rtl/a_input_debouncer_pkg.sv
// Shared types and constants for the pushbutton debouncer: FSM state encoding,
// glitch counter type and its saturating increment.
package a_input_debouncer_pkg;

    typedef enum logic [1:0] {
        IdleLow  = 2'b00,
        WaitHigh = 2'b01,
        IdleHigh = 2'b10,
        WaitLow  = 2'b11
    } deb_state_e;

    typedef logic [3:0] glitch_t;

    localparam glitch_t GLITCH_MAX = 4'hF;

    function automatic glitch_t sat_inc(input glitch_t v);
        return (v == GLITCH_MAX) ? v : v + 4'd1;
    endfunction

endpackage

// File: rtl/a_input_debouncer_if.sv
// Raw button in, debounced level, edge strobes and glitch count out.
interface a_input_debouncer_if;
    import a_input_debouncer_pkg::*;

    logic    btn_raw;
    logic    a;
    logic    a_rise;
    logic    a_fall;
    glitch_t glitch_cnt;

    modport master (
        output btn_raw,
        input  a,
        input  a_rise,
        input  a_fall,
        input  glitch_cnt
    );

    modport slave (
        input  btn_raw,
        output a,
        output a_rise,
        output a_fall,
        output glitch_cnt
    );

endinterface

// File: rtl/a_input_debouncer_sync_chain.sv
// Multi-flop synchroniser for an asynchronous single-bit input; q is the last stage.
module a_input_debouncer_sync_chain #(
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic reset,
    input  logic d,
    output logic q
);

    if (SYNC_STAGES < 2) begin : g_bad_stages
        $error("SYNC_STAGES must be at least 2");
    end

    logic [SYNC_STAGES-1:0] stages_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            stages_q <= '0;
        end else begin
            stages_q <= {stages_q[SYNC_STAGES-2:0], d};
        end
    end

    assign q = stages_q[SYNC_STAGES-1];

endmodule

// File: rtl/a_input_debouncer.sv
// Pushbutton debouncer: synchroniser followed by a qualification FSM that accepts a level
// change only after STABLE_CYCLES consecutive agreeing samples.
module a_input_debouncer
    import a_input_debouncer_pkg::*;
#(
    parameter int unsigned SYNC_STAGES   = 2,
    parameter int unsigned STABLE_CYCLES = 5,
    parameter int unsigned CNT_W         = 4
) (
    input logic                 clk,
    input logic                 reset,
    a_input_debouncer_if.slave  bus
);

    if (STABLE_CYCLES < 2 || (64'd1 << CNT_W) <= 64'(STABLE_CYCLES)) begin : g_bad_params
        $error("STABLE_CYCLES must be >= 2 and fit in CNT_W bits");
    end

    localparam logic [CNT_W-1:0] CntLast = CNT_W'(STABLE_CYCLES - 1);
    localparam logic [CNT_W-1:0] CntOne  = CNT_W'(1);

    logic s;

    a_input_debouncer_sync_chain #(
        .SYNC_STAGES (SYNC_STAGES)
    ) u_sync (
        .clk   (clk),
        .reset (reset),
        .d     (bus.btn_raw),
        .q     (s)
    );

    deb_state_e       state_q;
    logic [CNT_W-1:0] cnt_q;
    logic             a_q;
    logic             rise_q;
    logic             fall_q;
    glitch_t          glitch_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= IdleLow;
            cnt_q    <= '0;
            a_q      <= 1'b0;
            rise_q   <= 1'b0;
            fall_q   <= 1'b0;
            glitch_q <= '0;
        end else begin
            rise_q <= 1'b0;
            fall_q <= 1'b0;
            case (state_q)
                IdleLow: begin
                    if (s) begin
                        state_q <= WaitHigh;
                        cnt_q   <= CntOne;
                    end
                end
                WaitHigh: begin
                    if (!s) begin
                        state_q  <= IdleLow;
                        cnt_q    <= '0;
                        glitch_q <= sat_inc(glitch_q);
                    end else if (cnt_q == CntLast) begin
                        state_q <= IdleHigh;
                        a_q     <= 1'b1;
                        rise_q  <= 1'b1;
                        cnt_q   <= '0;
                    end else begin
                        cnt_q <= cnt_q + CntOne;
                    end
                end
                IdleHigh: begin
                    if (!s) begin
                        state_q <= WaitLow;
                        cnt_q   <= CntOne;
                    end
                end
                WaitLow: begin
                    if (s) begin
                        state_q  <= IdleHigh;
                        cnt_q    <= '0;
                        glitch_q <= sat_inc(glitch_q);
                    end else if (cnt_q == CntLast) begin
                        state_q <= IdleLow;
                        a_q     <= 1'b0;
                        fall_q  <= 1'b1;
                        cnt_q   <= '0;
                    end else begin
                        cnt_q <= cnt_q + CntOne;
                    end
                end
                // Recover from a corrupted state register to a known-quiet low level.
                default: begin
                    state_q <= IdleLow;
                    cnt_q   <= '0;
                    a_q     <= 1'b0;
                end
            endcase
        end
    end

    assign bus.a          = a_q;
    assign bus.a_rise     = rise_q;
    assign bus.a_fall     = fall_q;
    assign bus.glitch_cnt = glitch_q;

endmodule

// File: tb/tb_a_input_debouncer.sv
// Bench for a_input_debouncer: directed scenarios plus random bursts, every cycle compared
// against a run-length reference model of the debouncing rules.
module tb_a_input_debouncer;
    import a_input_debouncer_pkg::*;

    localparam int SYNC   = 2;
    localparam int STABLE = 5;

    logic clk   = 1'b0;
    logic reset = 1'b1;

    a_input_debouncer_if bus ();

    a_input_debouncer #(
        .SYNC_STAGES   (SYNC),
        .STABLE_CYCLES (STABLE),
        .CNT_W         (4)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #10 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    // Reference model: raw delay line, accepted level, length of current disagreeing run.
    logic sync_m [SYNC];
    logic a_m, rise_m, fall_m;
    int   run_m;
    int   glitch_m;

    task automatic check_eq(input string tag, input int got, input int exp);
        n_tests++;
        if (got != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_edge(input logic rst, input logic raw);
        logic s;
        if (rst) begin
            for (int i = 0; i < SYNC; i++) sync_m[i] = 1'b0;
            a_m      = 1'b0;
            rise_m   = 1'b0;
            fall_m   = 1'b0;
            run_m    = 0;
            glitch_m = 0;
        end else begin
            s = sync_m[SYNC-1];
            for (int i = SYNC - 1; i > 0; i--) sync_m[i] = sync_m[i-1];
            sync_m[0] = raw;
            rise_m = 1'b0;
            fall_m = 1'b0;
            if (s != a_m) begin
                run_m++;
                if (run_m == STABLE) begin
                    a_m    = s;
                    rise_m = s;
                    fall_m = !s;
                    run_m  = 0;
                end
            end else begin
                if (run_m > 0) glitch_m = (glitch_m < 15) ? glitch_m + 1 : 15;
                run_m = 0;
            end
        end
    endtask

    task automatic step(input logic rst, input logic raw);
        reset       = rst;
        bus.btn_raw = raw;
        @(posedge clk);
        model_edge(rst, raw);
        #1;
        check_eq("a", int'(bus.a), int'(a_m));
        check_eq("a_rise", int'(bus.a_rise), int'(rise_m));
        check_eq("a_fall", int'(bus.a_fall), int'(fall_m));
        check_eq("glitch_cnt", int'(bus.glitch_cnt), glitch_m);
    endtask

    // Drive a steady raw level until `a` reaches target; edges = 0 if it never does.
    task automatic hold_until(input logic raw, input logic target, output int edges);
        edges = 0;
        for (int i = 1; i <= 20; i++) begin
            step(1'b0, raw);
            if (bus.a == target) begin
                edges = i;
                break;
            end
        end
    endtask

    initial begin
        #2ms;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int lat;
        int fall_seen;
        logic lvl;
        int   len;

        bus.btn_raw = 1'b1;

        // Reset with raw high, then release: treated as a normal rise.
        repeat (3) step(1'b1, 1'b1);
        check_eq("rst_a", int'(bus.a), 0);
        check_eq("rst_rise", int'(bus.a_rise), 0);
        check_eq("rst_fall", int'(bus.a_fall), 0);
        check_eq("rst_glitch", int'(bus.glitch_cnt), 0);
        hold_until(1'b1, 1'b1, lat);
        check_eq("release_rise_lat", lat, 7);
        check_eq("release_rise_strobe", int'(bus.a_rise), 1);
        step(1'b0, 1'b1);
        check_eq("rise_one_cycle", int'(bus.a_rise), 0);

        // Clean fall, then clean rise held for 10 cycles.
        hold_until(1'b0, 1'b0, lat);
        check_eq("clean_fall_lat", lat, 7);
        repeat (3) step(1'b0, 1'b0);
        hold_until(1'b1, 1'b1, lat);
        check_eq("clean_rise_lat", lat, 7);
        repeat (3) step(1'b0, 1'b1);
        check_eq("clean_glitch", int'(bus.glitch_cnt), 0);

        // 1-cycle and 3-cycle pulses from low are rejected.
        hold_until(1'b0, 1'b0, lat);
        repeat (3) step(1'b0, 1'b0);
        step(1'b0, 1'b1);
        repeat (6) step(1'b0, 1'b0);
        repeat (3) step(1'b0, 1'b1);
        repeat (6) step(1'b0, 1'b0);
        check_eq("pulse_a", int'(bus.a), 0);
        check_eq("pulse_glitch", int'(bus.glitch_cnt), 2);

        // Bouncy release from high: one aborted WAIT_LOW, exactly one fall strobe.
        hold_until(1'b1, 1'b1, lat);
        repeat (3) step(1'b0, 1'b1);
        fall_seen = 0;
        step(1'b0, 1'b1);
        fall_seen += int'(bus.a_fall);
        step(1'b0, 1'b0);
        fall_seen += int'(bus.a_fall);
        step(1'b0, 1'b1);
        fall_seen += int'(bus.a_fall);
        hold_until(1'b0, 1'b0, lat);
        fall_seen += int'(bus.a_fall);
        repeat (3) begin
            step(1'b0, 1'b0);
            fall_seen += int'(bus.a_fall);
        end
        check_eq("bounce_fall_lat", lat, 7);
        check_eq("bounce_fall_count", fall_seen, 1);
        check_eq("bounce_glitch", int'(bus.glitch_cnt), 3);

        // Twenty rejected pulses saturate the glitch counter.
        step(1'b1, 1'b0);
        repeat (20) begin
            step(1'b0, 1'b1);
            repeat (3) step(1'b0, 1'b0);
        end
        check_eq("sat_glitch", int'(bus.glitch_cnt), 15);
        repeat (5) step(1'b0, 1'b0);
        check_eq("sat_hold", int'(bus.glitch_cnt), 15);

        // Reset during WAIT_HIGH with three qualifying samples taken.
        repeat (5) step(1'b0, 1'b1);
        step(1'b1, 1'b1);
        check_eq("midq_rst_a", int'(bus.a), 0);
        check_eq("midq_rst_rise", int'(bus.a_rise), 0);
        check_eq("midq_rst_glitch", int'(bus.glitch_cnt), 0);
        repeat (10) step(1'b0, 1'b1);

        // Random bursts of varying length with occasional resets.
        for (int b = 0; b < 600; b++) begin
            lvl = 1'($urandom_range(0, 1));
            len = (($urandom_range(0, 3) == 0) ? int'($urandom_range(5, 12))
                                                 : int'($urandom_range(1, 5)));
            for (int k = 0; k < len; k++) begin
                step(($urandom_range(0, 199) == 0) ? 1'b1 : 1'b0, lvl);
            end
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
